key_switch_input: RTL and testbench



---
 rtl/key_switch_input_if.sv | 25 ++
 rtl/key_switch_input.sv | 137 +++++++++++++
 tb/tb_key_switch_input.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/key_switch_input_if.sv
// MMIO register port between the processor bus and key_switch_input.
// The master drives strobes, address and write data; the slave returns registered read data.
interface key_switch_input_if;
  logic [1:0]  bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic [31:0] bus_readdata;

  modport master (
    output bus_address,
    output bus_read,
    output bus_write,
    output bus_writedata,
    input  bus_readdata
  );

  modport slave (
    input  bus_address,
    input  bus_read,
    input  bus_write,
    input  bus_writedata,
    output bus_readdata
  );
endinterface

// File: rtl/key_switch_input.sv
// Pushbutton/slide-switch receiver: sync, debounce, press detection, MMIO register port.
// Optional KEY_IRQ_EN adds an irq mask at word address 3 and a registered interrupt output.
module key_switch_input #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned NUM_SWITCHES    = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_KEYS-1:0]     key_n,
  input  logic [NUM_SWITCHES-1:0] switch,
  key_switch_input_if.slave       bus,
  output logic [NUM_KEYS-1:0]     key_pressed,
  output logic [NUM_KEYS-1:0]     key_press_pulse,
  output logic                    irq
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0]            key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [NUM_SWITCHES-1:0]        sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_KEYS-1:0]            deb_q, deb_d;
  logic [NUM_KEYS-1:0]            pulse_q, pulse_d;
  logic [NUM_KEYS-1:0]            flag_q, flag_d;
  logic [NUM_KEYS-1:0]            flag_clr;
  logic [31:0]                    rdata_q, rdata_d;
  logic [31:0]                    reg_val;

  // Keys are inverted on entry so that 1 means pressed everywhere inside.
  always_comb begin
    key_s1_d = ~key_n;
    key_s2_d = key_s1_q;
    sw_s1_d  = switch;
    sw_s2_d  = sw_s1_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        deb_d[i] = ~deb_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // A new press sets the flag even when the same bit is being cleared this cycle.
  always_comb begin
    pulse_d  = deb_d & ~deb_q;
    flag_clr = '0;
    if (bus.bus_write && (bus.bus_address == 2'd2)) begin
      flag_clr = bus.bus_writedata[NUM_KEYS-1:0];
    end
    flag_d = (flag_q & ~flag_clr) | pulse_d;
  end

`ifdef KEY_IRQ_EN
  logic [NUM_KEYS-1:0] mask_q, mask_d;
  logic                irq_q, irq_d;

  always_comb begin
    mask_d = mask_q;
    if (bus.bus_write && (bus.bus_address == 2'd3)) begin
      mask_d = bus.bus_writedata[NUM_KEYS-1:0];
    end
    irq_d = |(flag_q & mask_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Reads sample the pre-write register contents.
  always_comb begin
    case (bus.bus_address)
      2'd0:    reg_val = 32'(deb_q);
      2'd1:    reg_val = 32'(sw_s2_q);
      2'd2:    reg_val = 32'(flag_q);
`ifdef KEY_IRQ_EN
      default: reg_val = 32'(mask_q);
`else
      default: reg_val = '0;
`endif
    endcase
    rdata_d = bus.bus_read ? reg_val : rdata_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_s1_q <= '0;
      key_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      cnt_q    <= '0;
      deb_q    <= '0;
      pulse_q  <= '0;
      flag_q   <= '0;
      rdata_q  <= '0;
    end else begin
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      cnt_q    <= cnt_d;
      deb_q    <= deb_d;
      pulse_q  <= pulse_d;
      flag_q   <= flag_d;
      rdata_q  <= rdata_d;
    end
  end

  assign key_pressed      = deb_q;
  assign key_press_pulse  = pulse_q;
  assign bus.bus_readdata = rdata_q;

  logic unused_wdata;
  assign unused_wdata = ^bus.bus_writedata[31:NUM_KEYS];

endmodule

// File: tb/tb_key_switch_input.sv
// Directed plus randomized bench for key_switch_input (DEBOUNCE_CYCLES = 4) against a
// cycle-level behavioural model of the documented rules.
module tb_key_switch_input;
  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic [9:0] switch;
  logic [3:0] key_pressed, key_press_pulse;
  logic       irq;

  key_switch_input_if bus ();

  key_switch_input #(
    .NUM_KEYS        (4),
    .NUM_SWITCHES    (10),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .key_n           (key_n),
    .switch          (switch),
    .bus             (bus.slave),
    .key_pressed     (key_pressed),
    .key_press_pulse (key_press_pulse),
    .irq             (irq)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_mis = 0;

  // Model: pin history delayed two cycles, a run length of cycles the synced key has
  // disagreed with the accepted level, and the register file.
  logic [3:0]  m_dl1, m_dl2, m_deb, m_pulse, m_flag, m_mask;
  int          m_run [4];
  logic        m_irq;
  logic [9:0]  m_sw1, m_sw2;
  logic [31:0] m_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dl1 = '0; m_dl2 = '0; m_deb = '0; m_pulse = '0; m_flag = '0; m_mask = '0;
    m_irq = 1'b0; m_sw1 = '0; m_sw2 = '0; m_rd = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  function automatic logic [31:0] reg_value(input logic [1:0] a);
    case (a)
      2'd0: return {28'd0, m_deb};
      2'd1: return {22'd0, m_sw2};
      2'd2: return {28'd0, m_flag};
`ifdef KEY_IRQ_EN
      default: return {28'd0, m_mask};
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  task automatic model_step();
    logic [3:0] nd, clr;
    if (bus.bus_read) m_rd = reg_value(bus.bus_address);
    nd = m_deb;
    for (int i = 0; i < 4; i++) begin
      if (m_dl2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          nd[i] = ~nd[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_pulse = nd & ~m_deb;
`ifdef KEY_IRQ_EN
    m_irq = |(m_flag & m_mask);
    if (bus.bus_write && bus.bus_address == 2'd3) m_mask = bus.bus_writedata[3:0];
`endif
    clr = (bus.bus_write && bus.bus_address == 2'd2) ? bus.bus_writedata[3:0] : 4'd0;
    m_flag = (m_flag & ~clr) | m_pulse;
    m_deb = nd;
    m_dl2 = m_dl1;
    m_dl1 = ~key_n;
    m_sw2 = m_sw1;
    m_sw1 = switch;
  endtask

  task automatic compare_all();
    check("key_pressed", {28'd0, key_pressed}, {28'd0, m_deb});
    check("press_pulse", {28'd0, key_press_pulse}, {28'd0, m_pulse});
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    check("readdata", bus.bus_readdata, m_rd);
  endtask

  // Advance one clock; inputs may be changed by the caller once this returns.
  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  task automatic bus_idle();
    bus.bus_read = 1'b0;
    bus.bus_write = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a);
    bus.bus_address = a;
    bus.bus_read = 1'b1;
    tick();
    bus_idle();
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    bus.bus_address = a;
    bus.bus_writedata = d;
    bus.bus_write = 1'b1;
    tick();
    bus_idle();
  endtask

  initial begin
    reset = 1'b1;
    key_n = 4'hF;
    switch = '0;
    bus.bus_address = '0;
    bus.bus_writedata = '0;
    bus_idle();
    model_reset();
    repeat (2) tick();
    reset = 1'b0;

    // Reset state
    do_read(2'd0);
    check("rst_rd0", bus.bus_readdata, 32'h0);
    check("rst_kp", {28'd0, key_pressed}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);

    // Key 0 press: accepted exactly 2 + D cycles after the pin change
    key_n = 4'b1110;
    repeat (5) tick();
    check("kp0_cycle5", {28'd0, key_pressed}, 32'h0);
    tick();
    check("kp0_cycle6", {28'd0, key_pressed}, 32'h1);
    check("pulse0_cycle6", {28'd0, key_press_pulse}, 32'h1);
    tick();
    check("pulse0_cycle7", {28'd0, key_press_pulse}, 32'h0);
    repeat (3) tick();
    do_read(2'd2);
    check("flag_after_k0", bus.bus_readdata, 32'h1);

    // Key 1 glitch of 3 cycles is ignored
    key_n = 4'b1100;
    repeat (3) tick();
    key_n = 4'b1110;
    repeat (8) tick();
    check("glitch_kp", {28'd0, key_pressed}, 32'h1);
    do_read(2'd2);
    check("glitch_flag", bus.bus_readdata, 32'h1);

    // Clear flag 0 on the same edge key 2 is accepted
    key_n = 4'b1010;
    repeat (5) tick();
    do_write(2'd2, 32'h1);
    do_read(2'd2);
    check("set_and_clr", bus.bus_readdata, 32'h4);

    // Switches: synchronized only; writes to read-only words ignored
    switch = 10'b0000000011;
    repeat (3) tick();
    do_write(2'd1, 32'hFFFF_FFFF);
    do_write(2'd0, 32'hFFFF_FFFF);
    do_read(2'd1);
    check("switch_rd", bus.bus_readdata, 32'h3);

    // Reset in the middle of key 3 debouncing
    key_n = 4'b0010;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    model_reset();
    check("midrst_kp", {28'd0, key_pressed}, 32'h0);
    check("midrst_pulse", {28'd0, key_press_pulse}, 32'h0);
    check("midrst_rd", bus.bus_readdata, 32'h0);
    repeat (2) tick();
    reset = 1'b0;
    do_read(2'd2);
    check("midrst_flag", bus.bus_readdata, 32'h0);
    repeat (8) tick();

    // Interrupt behaviour
    key_n = 4'hF;
    repeat (10) tick();
    do_write(2'd2, 32'hF);
    do_write(2'd3, 32'h2);
`ifdef KEY_IRQ_EN
    key_n = 4'b1101;
    repeat (6) tick();
    check("irq_at_flag", {31'd0, irq}, 32'h0);
    tick();
    check("irq_after_flag", {31'd0, irq}, 32'h1);
    do_write(2'd2, 32'h2);
    tick();
    check("irq_after_clr", {31'd0, irq}, 32'h0);
    do_read(2'd3);
    check("mask_rd", bus.bus_readdata, 32'h2);
`else
    key_n = 4'b1101;
    repeat (10) tick();
    check("irq_tied", {31'd0, irq}, 32'h0);
    do_read(2'd3);
    check("addr3_rd", bus.bus_readdata, 32'h0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 5) == 0) key_n[k] = ~key_n[k];
      end
      if ($urandom_range(0, 15) == 0) switch = 10'($urandom);
      bus_idle();
      bus.bus_address = 2'($urandom_range(0, 3));
      bus.bus_writedata = $urandom;
      bus.bus_read = ($urandom_range(0, 1) == 1);
      bus.bus_write = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    bus_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
